// File: rtl/material_classifier.sv
// material_classifier: debounced sensor window reduced to a material class with valid/ready handoff
module material_classifier #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int WINDOW_CYCLES   = 25_000_000,
   parameter int CLEAR_CYCLES    = 50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        capacitive,
   input  logic        inductive,
   input  logic        photo,
   input  logic        class_ready,
   output logic        class_valid,
   output logic [1:0]  class_code,
   output logic        busy,
   output logic [15:0] item_count
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int WW = $clog2(WINDOW_CYCLES + 1);
   localparam int CW = $clog2(CLEAR_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, WINDOW, PRESENT, CLEAR} state_t;
   state_t        state_q, state_d;
   logic [2:0]    s1_q, s2_q, db_q, db_d;
   logic [DW-1:0] dcnt_q [3];
   logic [DW-1:0] dcnt_d [3];
   logic [WW-1:0] win_q, win_d;
   logic [CW-1:0] clr_q, clr_d;
   logic          ind_q, ind_d, ph_q, ph_d;
   logic [1:0]    code_q, code_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          cap_det;
   // bit 0 capacitive (active-low), bit 1 inductive, bit 2 photo
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         db_q    <= 3'b001;
         for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
         state_q <= IDLE;
         win_q   <= '0;
         clr_q   <= '0;
         ind_q   <= 1'b0;
         ph_q    <= 1'b0;
         code_q  <= 2'b00;
         cnt_q   <= '0;
      end else begin
         s1_q    <= {photo, inductive, capacitive};
         s2_q    <= s1_q;
         db_q    <= db_d;
         for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
         state_q <= state_d;
         win_q   <= win_d;
         clr_q   <= clr_d;
         ind_q   <= ind_d;
         ph_q    <= ph_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < 3; i++) begin
         dcnt_d[i] = (s2_q[i] != db_q[i] && dcnt_q[i] != DW'(DEBOUNCE_CYCLES - 1)) ? dcnt_q[i] + 1'b1 : '0;
         db_d[i]   = (s2_q[i] != db_q[i] && dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? s2_q[i] : db_q[i];
      end
   end
   assign cap_det = ~db_q[0];
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      clr_d   = clr_q;
      ind_d   = ind_q;
      ph_d    = ph_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (cap_det) begin
            state_d = WINDOW;
            win_d   = '0;
            ind_d   = db_q[1];
            ph_d    = db_q[2];
         end
         WINDOW: begin
            ind_d = ind_q | db_q[1];
            ph_d  = ph_q | db_q[2];
            win_d = win_q + 1'b1;
            if (win_q == WW'(WINDOW_CYCLES - 1)) begin
               state_d = PRESENT;
               code_d  = ind_d ? (ph_d ? 2'b01 : 2'b00) : (ph_d ? 2'b10 : 2'b11);
            end
         end
         PRESENT: if (class_ready) begin
            state_d = CLEAR;
            clr_d   = '0;
            cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 1'b1;
         end
         CLEAR: begin
            clr_d = cap_det ? '0 : clr_q + 1'b1;
            if (clr_q == CW'(CLEAR_CYCLES - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign class_valid = (state_q == PRESENT);
   assign class_code  = code_q;
   assign busy        = (state_q != IDLE);
   assign item_count  = cnt_q;
endmodule

// File: tb/tb_material_classifier.sv
// tb_material_classifier: directed and randomized item sequences against a table-driven class model
module tb_material_classifier;
   logic        clk = 1'b0, rst_n = 1'b0, capacitive = 1'b1, inductive = 1'b0, photo = 1'b0, class_ready = 1'b0;
   logic        class_valid, busy;
   logic [1:0]  class_code;
   logic [15:0] item_count;
   int          errors = 0, checks = 0, exp_count = 0;
   logic [1:0]  code_tab [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
   always #5 clk = ~clk;
   material_classifier #(.DEBOUNCE_CYCLES(4), .WINDOW_CYCLES(16), .CLEAR_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .capacitive(capacitive), .inductive(inductive), .photo(photo),
      .class_ready(class_ready), .class_valid(class_valid), .class_code(class_code),
      .busy(busy), .item_count(item_count)
   );
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
   endtask
   // sensors held steady for the whole item; hold>0 keeps the object present after handoff
   task automatic run_item(input bit ind, input bit ph, input int delay, input int hold, input string tag);
      logic [1:0] exp_code;
      exp_code    = code_tab[{ind, ph}];
      inductive   = ind;
      photo       = ph;
      class_ready = (delay == 0);
      tick(8);
      capacitive = 1'b0;
      tick(6);
      chk({tag, "_busy_pre"}, {15'd0, busy}, 16'd0);
      tick();
      chk({tag, "_busy_win"}, {15'd0, busy}, 16'd1);
      tick(15);
      chk({tag, "_valid_early"}, {15'd0, class_valid}, 16'd0);
      tick();
      chk({tag, "_valid"}, {15'd0, class_valid}, 16'd1);
      chk({tag, "_code"}, {14'd0, class_code}, {14'd0, exp_code});
      for (int i = 0; i < delay; i++) begin
         tick();
         chk({tag, "_valid_hold"}, {15'd0, class_valid}, 16'd1);
         chk({tag, "_code_hold"}, {14'd0, class_code}, {14'd0, exp_code});
         chk({tag, "_count_hold"}, item_count, 16'(exp_count));
      end
      class_ready = 1'b1;
      tick();
      exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 1;
      chk({tag, "_valid_drop"}, {15'd0, class_valid}, 16'd0);
      chk({tag, "_count"}, item_count, 16'(exp_count));
      class_ready = 1'b0;
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_clear_busy"}, {15'd0, busy}, 16'd1);
            chk({tag, "_clear_valid"}, {15'd0, class_valid}, 16'd0);
         end
         capacitive = 1'b1;
         tick(13);
         chk({tag, "_release_busy"}, {15'd0, busy}, 16'd1);
         tick();
         chk({tag, "_release_idle"}, {15'd0, busy}, 16'd0);
         chk({tag, "_release_count"}, item_count, 16'(exp_count));
      end else begin
         capacitive = 1'b1;
         wait_idle(tag);
      end
   endtask
   initial begin
      tick(3);
      chk("rst_valid", {15'd0, class_valid}, 16'd0);
      chk("rst_code", {14'd0, class_code}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_count", item_count, 16'd0);
      rst_n = 1'b1;
      tick(2);
      run_item(1'b1, 1'b1, 0, 0, "metal");
      inductive   = 1'b0;
      photo       = 1'b0;
      class_ready = 1'b1;
      tick(8);
      capacitive = 1'b0;
      tick(8);
      photo = 1'b1;
      tick(2);
      capacitive = 1'b1;
      tick(3);
      photo = 1'b0;
      tick(9);
      chk("sticky_valid_early", {15'd0, class_valid}, 16'd0);
      tick();
      chk("sticky_valid", {15'd0, class_valid}, 16'd1);
      chk("sticky_code", {14'd0, class_code}, 16'd2);
      tick();
      exp_count++;
      chk("sticky_count", item_count, 16'(exp_count));
      class_ready = 1'b0;
      wait_idle("sticky");
      run_item(1'b0, 1'b0, 20, 0, "glass_wait");
      run_item(1'b1, 1'b0, 2, 0, "unknown");
      for (int k = 0; k < 10; k++) begin
         bit ri, rp;
         ri = 1'($urandom_range(0, 1));
         rp = 1'($urandom_range(0, 1));
         run_item(ri, rp, int'($urandom_range(0, 4)), 0, "rand");
      end
      for (int i = 0; i < 20; i++) begin
         capacitive = (i % 2 == 1);
         tick(2);
         chk("bounce_busy", {15'd0, busy}, 16'd0);
      end
      tick(10);
      chk("bounce_after", {15'd0, busy}, 16'd0);
      run_item(1'b0, 1'b1, 0, 10, "hold");
      inductive = 1'b1;
      photo     = 1'b1;
      tick(8);
      capacitive = 1'b0;
      tick(12);
      chk("midrst_busy_pre", {15'd0, busy}, 16'd1);
      rst_n      = 1'b0;
      capacitive = 1'b1;
      tick();
      rst_n     = 1'b1;
      exp_count = 0;
      chk("midrst_busy", {15'd0, busy}, 16'd0);
      chk("midrst_valid", {15'd0, class_valid}, 16'd0);
      chk("midrst_count", item_count, 16'(exp_count));
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("midrst_no_class", {15'd0, class_valid}, 16'd0);
      end
      chk("midrst_count_end", item_count, 16'(exp_count));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
